// File: rtl/sha_auth_pkg.sv
// Shared types and sizes for the SHA authentication loader.
// Build option: SHA_AUTH_LOCKOUT_EN enables the failed-attempt lockout.
package sha_auth_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_BLK,
        S_LOAD_DIG,
        S_INIT,
        S_WAIT,
        S_DONE
    } state_e;

    localparam int unsigned BLOCK_WORDS  = 8;
    localparam int unsigned DIGEST_WORDS = 8;

endpackage

// File: rtl/sha_auth_timer.sv
// Loadable down-counter with zero flag; paces the hash compute window.
// Build option: none (see SHA_AUTH_LOCKOUT_EN in the top).
module sha_auth_timer #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over counting; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sha_auth_loader.sv
// Streams block + expected digest into the SHA authenticator and reports pass/fail.
// Build option: define SHA_AUTH_LOCKOUT_EN to lock out after MAX_FAILS failures.
module sha_auth_loader
    import sha_auth_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 80
`ifdef SHA_AUTH_LOCKOUT_EN
    ,
    parameter int unsigned MAX_FAILS = 3
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        sha_cs,
    output logic        sha_we,
    output logic        sha_wc,
    output logic [2:0]  sha_address,
    output logic [31:0] sha_write_data,
    input  logic        sha_digest_valid,
    output logic        busy,
    output logic        done,
    output logic        auth_pass,
    output logic        auth_fail,
    output logic        locked
);

    localparam int unsigned TW = $clog2(WAIT_CYCLES);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(WAIT_CYCLES - 1);
    localparam logic [3:0] BLK_LAST = 4'(BLOCK_WORDS - 1);
    localparam logic [3:0] DIG_LAST = 4'(DIGEST_WORDS - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rdy_q, rdy_d;
    logic        cs_q, cs_d;
    logic        we_q, we_d;
    logic        wc_q, wc_d;
    logic [2:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        tmr_load, tmr_en, tmr_zero;
    logic        locked_lvl;
    logic        xfer;
    logic        judge;

    assign xfer  = in_valid && rdy_q;
    assign judge = (state_q == S_WAIT) && tmr_zero && !abort;

    sha_auth_timer #(
        .W(TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (WAIT_LOAD),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    // Next-state and registered-output logic; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cs_d     = 1'b0;
        we_d     = 1'b0;
        wc_d     = wc_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        fail_d   = fail_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !locked_lvl) begin
                    state_d = S_LOAD_BLK;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            S_LOAD_BLK, S_LOAD_DIG: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    wc_d    = (state_q == S_LOAD_BLK);
                    addr_d  = cnt_q[2:0];
                    wdata_d = in_data;
                    if (state_q == S_LOAD_BLK && cnt_q == BLK_LAST) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_DIG;
                    end else if (state_q == S_LOAD_DIG && cnt_q == DIG_LAST) begin
                        cnt_d   = '0;
                        state_d = S_INIT;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_INIT: begin
                cs_d     = 1'b1;
                tmr_load = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (tmr_zero) begin
                    pass_d  = sha_digest_valid;
                    fail_d  = !sha_digest_valid;
                    state_d = S_DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            cs_d     = 1'b0;
            we_d     = 1'b0;
            wc_d     = wc_q;
            addr_d   = addr_q;
            wdata_d  = wdata_q;
            done_d   = 1'b0;
            pass_d   = pass_q;
            fail_d   = fail_q;
            tmr_load = 1'b0;
            tmr_en   = 1'b0;
        end
        rdy_d  = (state_d == S_LOAD_BLK) || (state_d == S_LOAD_DIG);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    // State and output registers; reset clears every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            wc_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            wc_q    <= wc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

`ifdef SHA_AUTH_LOCKOUT_EN
    localparam int unsigned FW = $clog2(MAX_FAILS + 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);

    logic [FW-1:0] fails_q, fails_d;
    logic          locked_q, locked_d;

    // Saturating consecutive-failure count; a pass clears it.
    always_comb begin
        fails_d  = fails_q;
        locked_d = locked_q;
        if (judge) begin
            if (sha_digest_valid) begin
                fails_d = '0;
            end else if (fails_q != FAIL_MAX) begin
                fails_d = fails_q + FW'(1);
            end
        end
        if (fails_d == FAIL_MAX) begin
            locked_d = 1'b1;
        end
    end

    // Lockout registers; only reset releases the lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            fails_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            fails_q  <= fails_d;
            locked_q <= locked_d;
        end
    end

    assign locked_lvl = locked_q;
`else
    logic unused_judge;
    assign unused_judge = judge;
    assign locked_lvl   = 1'b0;
`endif

    assign in_ready       = rdy_q;
    assign sha_cs         = cs_q;
    assign sha_we         = we_q;
    assign sha_wc         = wc_q;
    assign sha_address    = addr_q;
    assign sha_write_data = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign auth_pass      = pass_q;
    assign auth_fail      = fail_q;
    assign locked         = locked_lvl;

endmodule

// File: tb/tb_sha_auth_loader.sv
// Directed bench for sha_auth_loader with a behavioural authenticator stand-in.
// Build option: SHA_AUTH_LOCKOUT_EN selects the lockout expectations.
module tb_sha_auth_loader;

`ifdef SHA_AUTH_LOCKOUT_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        sha_digest_valid = 1'b1;
    logic        in_ready, sha_cs, sha_we, sha_wc;
    logic [2:0]  sha_address;
    logic [31:0] sha_write_data;
    logic        busy, done, auth_pass, auth_fail, locked;
    logic [43:0] outs;

    sha_auth_loader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .sha_cs           (sha_cs),
        .sha_we           (sha_we),
        .sha_wc           (sha_wc),
        .sha_address      (sha_address),
        .sha_write_data   (sha_write_data),
        .sha_digest_valid (sha_digest_valid),
        .busy             (busy),
        .done             (done),
        .auth_pass        (auth_pass),
        .auth_fail        (auth_fail),
        .locked           (locked)
    );

    assign outs = {in_ready, sha_cs, sha_we, sha_wc, sha_address,
                   sha_write_data, busy, done, auth_pass, auth_fail, locked};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    int          wr_n = 0, cs_n = 0, done_n = 0;
    int          cs_cyc = 0, done_cyc = 0;
    logic [35:0] wr_word [32];
    int          wr_cyc [32];
    int          acc_cyc [16];
    logic        pass_at_done, fail_at_done;

    logic [31:0] blk_w [8];
    logic [31:0] dig_w [8];
    logic        bad3 = 1'b0;

    // Authenticator-side observer: logs every strobe seen on the port.
    always @(negedge clk) begin
        if (sha_we && wr_n < 32) begin
            wr_word[wr_n] = {sha_wc, sha_address, sha_write_data};
            wr_cyc[wr_n]  = cyc;
            wr_n++;
        end
        if (sha_cs) begin
            cs_n++;
            cs_cyc = cyc;
        end
        if (done) begin
            done_n++;
            done_cyc     = cyc;
            pass_at_done = auth_pass;
            fail_at_done = auth_fail;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int i);
        logic [31:0] w;
        if (i < 8) w = blk_w[i];
        else w = dig_w[i-8];
        if (i == 11 && bad3) w = w ^ 32'h0000_0100;
        return w;
    endfunction

    task automatic clr_log();
        wr_n   = 0;
        cs_n   = 0;
        done_n = 0;
    endtask

    // Start a session and push `nwords` words (continuous or every other cycle).
    task automatic feed(input string nm, input bit toggle, input int nwords,
                        output int c0);
        int idx;
        int k;
        clr_log();
        start = 1'b1;
        c0 = cyc;
        step();
        start = 1'b0;
        idx = 0;
        k = 0;
        while (idx < nwords && k < 100) begin
            in_valid = toggle ? ((k % 2) == 0) : 1'b1;
            in_data  = word(idx);
            @(negedge clk);
            if (k == 0)
                chk({nm, "_busy_clr"}, 64'({busy, auth_pass, auth_fail}), 64'b100);
            if (in_valid && in_ready) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            step();
            k++;
        end
        in_valid = 1'b0;
        chk({nm, "_feed"}, 64'(idx), 64'(nwords));
    endtask

    task automatic session(input string nm, input bit bad, input bit toggle,
                           input bit poke);
        int c0;
        int g;
        bad3 = bad;
        sha_digest_valid = 1'b1;
        feed(nm, toggle, 16, c0);
        g = 0;
        while (done_n == 0 && g < 300) begin
            if (bad && cs_n > 0 && cyc >= cs_cyc + 79) sha_digest_valid = 1'b0;
            start = (poke && cs_n > 0 && cyc == cs_cyc + 20);
            step();
            g++;
        end
        start = 1'b0;
        chk({nm, "_done_n"}, 64'(done_n), 64'd1);
        chk({nm, "_cs_n"}, 64'(cs_n), 64'd1);
        chk({nm, "_wr_n"}, 64'(wr_n), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_wr%0d", nm, i), 64'(wr_word[i]),
                64'({(i < 8), 3'(i), word(i)}));
            chk($sformatf("%s_lat%0d", nm, i), 64'(wr_cyc[i]),
                64'(acc_cyc[i] + 1));
        end
        chk({nm, "_cs2done"}, 64'(done_cyc - cs_cyc), 64'd81);
        if (!toggle) begin
            chk({nm, "_cs_cyc"}, 64'(cs_cyc - c0), 64'd18);
            chk({nm, "_done_cyc"}, 64'(done_cyc - c0), 64'd99);
        end
        chk({nm, "_result"}, 64'({pass_at_done, fail_at_done}),
            bad ? 64'b01 : 64'b10);
        @(negedge clk);
        chk({nm, "_hold"}, 64'({busy, done, auth_pass, auth_fail}),
            64'({2'b00, !bad, bad}));
    endtask

    initial begin
        int c0;
        int g;
        blk_w = '{32'h4c4e4953, 32'h6c6e6973, 32'h4c4e4953, 32'h6c6e6973,
                  32'h4c4e4953, 32'h6c6e6973, 32'h4c4e4953, 32'h6c6e6973};
        dig_w = '{32'he42c30a6, 32'h5d3f81b2, 32'h09c47e1d, 32'h7a66f0c3,
                  32'h2b8e91d4, 32'hc05a37e8, 32'h91f2d6ab, 32'h3e0b74f5};

        repeat (3) step();
        @(negedge clk);
        chk("rst_outs", 64'(outs), 64'd0);
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("idle_outs", 64'(outs), 64'd0);

        session("pass", 1'b0, 1'b0, 1'b0);
        session("fail", 1'b1, 1'b0, 1'b0);
        session("tog", 1'b0, 1'b1, 1'b0);
        session("poke", 1'b0, 1'b0, 1'b1);

        bad3 = 1'b0;
        feed("abt", 1'b0, 5, c0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("abt_idle", 64'({busy, in_ready}), 64'd0);
        repeat (100) step();
        chk("abt_cs", 64'(cs_n), 64'd0);
        chk("abt_wr", 64'(wr_n), 64'd5);
        chk("abt_done", 64'(done_n), 64'd0);
        session("after_abt", 1'b0, 1'b0, 1'b0);

        clr_log();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("abt_start", 64'({busy, in_ready}), 64'd0);
        repeat (20) step();
        chk("abt_start_wr", 64'(wr_n), 64'd0);

        feed("rstw", 1'b0, 16, c0);
        g = 0;
        while (cs_n == 0 && g < 50) begin
            step();
            g++;
        end
        chk("rstw_cs", 64'(cs_n), 64'd1);
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_outs", 64'(outs), 64'd0);
        repeat (100) step();
        chk("rstw_done", 64'(done_n), 64'd0);

        for (int i = 0; i < 3; i++) begin
            session($sformatf("lk%0d", i), 1'b1, 1'b0, 1'b0);
            chk($sformatf("lk%0d_locked", i), 64'(locked),
                64'(LOCK && (i == 2)));
        end
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("lk_start", 64'(busy), 64'(!LOCK));
        abort = 1'b1;
        step();
        abort = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("lk_clear", 64'(locked), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
